// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and execute.
// The slave modport is the decode_queue view; master is the fetch/execute side.
interface decode_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_id;
   logic [XLEN-1:0] out_rs;
   logic [XLEN-1:0] out_rt;
   logic [XLEN-1:0] out_rd;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;
   logic [LW-1:0]   level;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_id, out_rs, out_rt, out_rd, out_pc, out_illegal, level
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_id, out_rs, out_rt, out_rd, out_pc, out_illegal, level
   );
endinterface

// File: rtl/decode_queue.sv
// Instruction queue feeding a registered decode stage: buffers raw words from
// fetch and presents the head decoded into ID/rs/rt/rd with an illegal flag.
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   decode_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] id;
      logic [XLEN-1:0] rs;
      logic [XLEN-1:0] rt;
      logic [XLEN-1:0] rd;
      logic            illegal;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] ir);
      logic [5:0] op;
      logic [5:0] fn;
      logic       legal;
      dec_t       d;
      op    = ir[31:26];
      fn    = ir[5:0];
      d     = '0;
      legal = 1'b0;
      case (op) inside
         6'd0:          begin legal = (fn < 6'd4); d.id = XLEN'(fn) + XLEN'(6'd1);  end
         [6'd1:6'd6]:   begin legal = 1'b1;        d.id = XLEN'(op) + XLEN'(6'd4);  end
         6'd7:          begin legal = (fn < 6'd2); d.id = XLEN'(fn) + XLEN'(6'd11); end
         [6'd8:6'd21]:  begin legal = 1'b1;        d.id = XLEN'(op) + XLEN'(6'd5);  end
         default:       begin legal = 1'b0;        d.id = '0;                       end
      endcase
      case (op) inside
         6'd0, 6'd3, 6'd4, 6'd19: begin
            d.rs = XLEN'(ir[25:21]);
            d.rt = XLEN'(ir[20:16]);
            d.rd = XLEN'(ir[15:11]);
         end
         6'd1, 6'd2, 6'd5, 6'd6, 6'd7, [6'd8:6'd15], 6'd20: begin
            d.rs = XLEN'(ir[25:21]);
            d.rt = {{(XLEN-16){ir[15]}}, ir[15:0]};
            d.rd = XLEN'(ir[20:16]);
         end
         [6'd16:6'd18]: begin
            d.rs = XLEN'(ir[25:0]);
         end
         default: begin
            d.rs = '0;
         end
      endcase
      if (legal) begin
         d.illegal = 1'b0;
      end else begin
         d         = '0;
         d.illegal = 1'b1;
      end
      return d;
   endfunction

   logic [31:0]     instr_mem_q [DEPTH];
   logic [31:0]     instr_mem_d [DEPTH];
   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] pc_mem_d    [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            out_valid_q, out_valid_d;
   dec_t            out_dec_q, out_dec_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;

   logic            in_ready_s;
   logic            push_s;
   logic            pop_s;

   // Full queue never accepts, even if the head is leaving this cycle.
   assign in_ready_s = !reset && (level_q < FULL_LVL) && !bus.flush;
   assign push_s     = bus.in_valid && in_ready_s;
   assign pop_s      = (level_q != {LW{1'b0}}) && (!out_valid_q || bus.out_ready) && !bus.flush;

   // Next-state for queue storage, pointers, occupancy and the decode register.
   always_comb begin
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      out_valid_d = out_valid_q;
      out_dec_d   = out_dec_q;
      out_pc_d    = out_pc_q;
      if (bus.flush) begin
         wr_ptr_d    = {AW{1'b0}};
         rd_ptr_d    = {AW{1'b0}};
         level_d     = {LW{1'b0}};
         out_valid_d = 1'b0;
      end else begin
         if (push_s) begin
            instr_mem_d[wr_ptr_q] = bus.in_instr;
            pc_mem_d[wr_ptr_q]    = bus.in_pc;
            wr_ptr_d              = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + AW'(1'b1);
            out_valid_d = 1'b1;
            out_dec_d   = decode(instr_mem_q[rd_ptr_q]);
            out_pc_d    = pc_mem_q[rd_ptr_q];
         end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
         case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
         endcase
      end
   end

   // State registers; reset clears storage as well as control.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= 32'd0;
            pc_mem_q[i]    <= '0;
         end
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         level_q     <= {LW{1'b0}};
         out_valid_q <= 1'b0;
         out_dec_q   <= '0;
         out_pc_q    <= '0;
      end else begin
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_dec_q   <= out_dec_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_id      = out_dec_q.id;
   assign bus.out_rs      = out_dec_q.rs;
   assign bus.out_rt      = out_dec_q.rt;
   assign bus.out_rd      = out_dec_q.rd;
   assign bus.out_illegal = out_dec_q.illegal;
   assign bus.out_pc      = out_pc_q;
   assign bus.level       = level_q;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue (XLEN=64, DEPTH=4): expected decodes are
// queued on every accepted push and matched against each consumed output.
module tb_decode_queue;
   localparam int XLEN  = 64;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [63:0] id;
      logic [63:0] rs;
      logic [63:0] rt;
      logic [63:0] rd;
      logic [63:0] pc;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t exp_q[$];
   exp_t expd_q[$];
   exp_t obs_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   push_cnt = 0;

   always #5 clk = ~clk;

   decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
   decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   function automatic exp_t model(input logic [31:0] ir, input logic [63:0] pc);
      exp_t e;
      int   op;
      int   fn;
      op   = int'(ir[31:26]);
      fn   = int'(ir[5:0]);
      e    = '0;
      e.pc = pc;
      if (op == 0 && fn <= 3)          e.id = 64'(fn + 1);
      else if (op >= 1 && op <= 6)     e.id = 64'(op + 4);
      else if (op == 7 && fn <= 1)     e.id = 64'(fn + 11);
      else if (op >= 8 && op <= 21)    e.id = 64'(op + 5);
      else                             e.id = 64'd0;
      e.ill = (e.id == 64'd0);
      if (!e.ill) begin
         if (op == 0 || op == 3 || op == 4 || op == 19) begin
            e.rs = 64'(ir[25:21]); e.rt = 64'(ir[20:16]); e.rd = 64'(ir[15:11]);
         end else if (op <= 15 || op == 20) begin
            e.rs = 64'(ir[25:21]); e.rt = {{48{ir[15]}}, ir[15:0]}; e.rd = 64'(ir[20:16]);
         end else if (op <= 18) begin
            e.rs = 64'(ir[25:0]);
         end
      end
      return e;
   endfunction

   // One clock: record consumption and accepted pushes at the negedge, then step past the edge.
   task automatic tick();
      exp_t o;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && !bus.flush && !reset) begin
         o.id = bus.out_id; o.rs = bus.out_rs; o.rt = bus.out_rt; o.rd = bus.out_rd;
         o.pc = bus.out_pc; o.ill = bus.out_illegal;
         obs_q.push_back(o);
         if (exp_q.size() > 0) expd_q.push_back(exp_q.pop_front());
         else                  expd_q.push_back('1);
      end
      if (bus.flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) begin
         exp_q.push_back(model(bus.in_instr, bus.in_pc));
         push_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ir);
      bus.in_valid = 1'b1;
      bus.in_instr = ir;
      bus.in_pc    = {$urandom, $urandom};
   endtask

   task automatic test_reset();
      logic [31:0] ir;
      exp_t        e;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 64'd0;
      bus.flush = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.level, bus.out_valid, bus.in_ready} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctl: got level=%0d out_valid=%0b in_ready=%0b, want 0/0/0", bus.level, bus.out_valid, bus.in_ready);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_release_ready: got %0b want 1", bus.in_ready);
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         drive({6'(i + 8), 26'($urandom)});
         tick();
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.level !== 3'd3 || bus.out_valid !== 1'b1) begin
         n_err++; $display("FAIL reset_prefill: got level=%0d out_valid=%0b want 3/1", bus.level, bus.out_valid);
      end
      #3;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus.level, bus.out_valid, bus.in_ready, bus.out_id, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_pc, bus.out_illegal} !== '0) begin
         n_err++; $display("FAIL reset_async: got level=%0d out_valid=%0b in_ready=%0b id=%0h pc=%0h ill=%0b, want all 0",
                           bus.level, bus.out_valid, bus.in_ready, bus.out_id, bus.out_pc, bus.out_illegal);
      end
      exp_q.delete(); expd_q.delete(); obs_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      ir = 32'h00221801;
      drive(ir);
      e = model(ir, bus.in_pc);
      tick();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_first_latency1: got out_valid=%0b want 0", bus.out_valid);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== e.id || bus.out_pc !== e.pc) begin
         n_err++; $display("FAIL reset_first_latency2: got valid=%0b id=%0h pc=%0h want 1 %0h %0h", bus.out_valid, bus.out_id, bus.out_pc, e.id, e.pc);
      end
      bus.out_ready = 1'b1;
      tick();
      for (int i = 0; i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== expd_q[i]) begin
            n_err++; $display("FAIL sb_reset[%0d]: got %h want %h", i, obs_q[i], expd_q[i]);
         end
      end
      obs_q.delete(); expd_q.delete();
   endtask

   task automatic test_rtype();
      drive(32'h00221801);
      tick();
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL rtype_early: got out_valid=%0b want 0", bus.out_valid);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== 64'd2 || bus.out_rs !== 64'd1 || bus.out_rt !== 64'd2 ||
          bus.out_rd !== 64'd3 || bus.out_illegal !== 1'b0) begin
         n_err++; $display("FAIL rtype_sub: got v=%0b id=%0d rs=%0d rt=%0d rd=%0d ill=%0b want 1 2 1 2 3 0",
                           bus.out_valid, bus.out_id, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_illegal);
      end
      tick();
      for (int i = 0; i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== expd_q[i]) begin
            n_err++; $display("FAIL sb_rtype[%0d]: got %h want %h", i, obs_q[i], expd_q[i]);
         end
      end
      obs_q.delete(); expd_q.delete();
   endtask

   task automatic test_itype();
      drive({6'd1, 5'd4, 5'd5, 16'hFFFF});
      tick();
      drive({6'd18, 26'h3FFFFFF});
      tick();
      bus.in_valid = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (obs_q.size() != 2) begin
         n_err++; $display("FAIL itype_count: got %0d want 2", obs_q.size());
      end else begin
         n_cmp++;
         if (obs_q[0].id !== 64'd5 || obs_q[0].rt !== 64'hFFFF_FFFF_FFFF_FFFF || obs_q[0].rs !== 64'd4 || obs_q[0].rd !== 64'd5) begin
            n_err++; $display("FAIL itype_addi: got id=%0d rs=%0h rt=%h rd=%0h", obs_q[0].id, obs_q[0].rs, obs_q[0].rt, obs_q[0].rd);
         end
         n_cmp++;
         if (obs_q[1].id !== 64'd23 || obs_q[1].rs !== 64'h3FFFFFF || obs_q[1].rt !== 64'd0 || obs_q[1].rd !== 64'd0) begin
            n_err++; $display("FAIL itype_jal: got id=%0d rs=%0h rt=%0h rd=%0h want 23 3ffffff 0 0", obs_q[1].id, obs_q[1].rs, obs_q[1].rt, obs_q[1].rd);
         end
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== expd_q[i]) begin
            n_err++; $display("FAIL sb_itype[%0d]: got %h want %h", i, obs_q[i], expd_q[i]);
         end
      end
      obs_q.delete(); expd_q.delete();
   endtask

   task automatic test_backpressure();
      int start_cnt;
      bus.out_ready = 1'b0;
      start_cnt = push_cnt;
      for (int i = 0; i < 8; i++) begin
         drive({6'($urandom_range(0, 21)), 20'($urandom), 6'($urandom_range(0, 3))});
         tick();
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (push_cnt - start_cnt != 5 || bus.level !== 3'd4 || bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_fill: got accepted=%0d level=%0d in_ready=%0b want 5/4/0", push_cnt - start_cnt, bus.level, bus.in_ready);
      end
      bus.out_ready = 1'b1;
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.level !== 3'd3) begin
         n_err++; $display("FAIL bp_ready_return: got in_ready=%0b level=%0d want 1/3", bus.in_ready, bus.level);
      end
      repeat (4) tick();
      n_cmp++;
      if (obs_q.size() != 5 || bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_drain: got %0d outputs out_valid=%0b want 5/0", obs_q.size(), bus.out_valid);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== expd_q[i]) begin
            n_err++; $display("FAIL sb_bp[%0d]: got %h want %h", i, obs_q[i], expd_q[i]);
         end
      end
      obs_q.delete(); expd_q.delete();
   endtask

   task automatic test_flush();
      int start_cnt;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive({6'(i + 1), 26'($urandom)});
         tick();
      end
      n_cmp++;
      if (bus.level !== 3'd3 || bus.out_valid !== 1'b1) begin
         n_err++; $display("FAIL flush_prefill: got level=%0d out_valid=%0b want 3/1", bus.level, bus.out_valid);
      end
      start_cnt = push_cnt;
      bus.flush = 1'b1;
      bus.out_ready = 1'b1;
      drive(32'h00221801);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready);
      end
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || push_cnt != start_cnt) begin
         n_err++; $display("FAIL flush_clear: got level=%0d out_valid=%0b accepted=%0d want 0/0/0", bus.level, bus.out_valid, push_cnt - start_cnt);
      end
      repeat (3) tick();
      n_cmp++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++; $display("FAIL flush_residue: got %0d outputs %0d pending want 0/0", obs_q.size(), exp_q.size());
      end
      obs_q.delete(); expd_q.delete();
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      drive({6'd63, 26'($urandom)});                   tick();
      drive({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd7});      tick();
      drive({6'd7, 5'd1, 5'd2, 16'h0002});             tick();
      drive({6'd4, 5'd6, 5'd7, 5'd8, 5'd0, 6'd0});      tick();
      bus.in_valid = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (obs_q.size() != 4) begin
         n_err++; $display("FAIL illegal_count: got %0d want 4", obs_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs_q[i].ill !== 1'b1 || {obs_q[i].id, obs_q[i].rs, obs_q[i].rt, obs_q[i].rd} !== 256'd0) begin
               n_err++; $display("FAIL illegal_%0d: got ill=%0b id=%0h rs=%0h rt=%0h rd=%0h want 1 0 0 0 0",
                                 i, obs_q[i].ill, obs_q[i].id, obs_q[i].rs, obs_q[i].rt, obs_q[i].rd);
            end
         end
         n_cmp++;
         if (obs_q[3].ill !== 1'b0 || obs_q[3].id !== 64'd8 || obs_q[3].rs !== 64'd6 || obs_q[3].rt !== 64'd7 || obs_q[3].rd !== 64'd8) begin
            n_err++; $display("FAIL illegal_recover: got ill=%0b id=%0d rs=%0d rt=%0d rd=%0d want 0 8 6 7 8",
                              obs_q[3].ill, obs_q[3].id, obs_q[3].rs, obs_q[3].rt, obs_q[3].rd);
         end
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== expd_q[i]) begin
            n_err++; $display("FAIL sb_illegal[%0d]: got %h want %h", i, obs_q[i], expd_q[i]);
         end
      end
      obs_q.delete(); expd_q.delete();
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive({6'($urandom_range(0, 23)), 20'($urandom), 6'($urandom_range(0, 4))});
         tick();
      end
      bus.in_valid = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (obs_q.size() != 20) begin
         n_err++; $display("FAIL b2b_throughput: got %0d outputs want 20", obs_q.size());
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== expd_q[i]) begin
            n_err++; $display("FAIL sb_b2b[%0d]: got %h want %h", i, obs_q[i], expd_q[i]);
         end
      end
      obs_q.delete(); expd_q.delete();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 7) drive({6'($urandom_range(0, 25)), 20'($urandom), 6'($urandom_range(0, 4))});
         else                          bus.in_valid = 1'b0;
         bus.out_ready = ($urandom_range(0, 9) < 6);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) tick();
      n_cmp++;
      if (exp_q.size() != 0 || bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL rand_drain: got pending=%0d level=%0d out_valid=%0b want 0/0/0", exp_q.size(), bus.level, bus.out_valid);
      end
      for (int i = 0; i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== expd_q[i]) begin
            n_err++; $display("FAIL sb_rand[%0d]: got %h want %h", i, obs_q[i], expd_q[i]);
         end
      end
      obs_q.delete(); expd_q.delete();
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_backpressure();
      test_flush();
      test_illegal();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised instruction-decode stage with an input instruction queue and valid/ready handshakes on both sides. It accepts raw 32-bit instructions and their PC from fetch, buffers up to DEPTH of them, and decodes the queue head into the processor's instruction ID and three operands (rs, rt, rd) in a registered output stage. It also flags illegal encodings and supports a pipeline flush for taken branches and jumps. The block sits between instruction fetch and execute, and replaces direct combinational decode in the processor FSM.

## Interface
- XLEN, 32: operand/PC/ID width; must be ≥ 32.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept one instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  synchronous discard of all queued and output-stage instructions.
- out_valid  out  1  decoded instruction held on outputs.
- out_ready  in  1  consumer takes the output this cycle.
- out_id  out  XLEN  instruction ID (1–26); 0 if illegal.
- out_rs, out_rt, out_rd  out  XLEN  extracted operands.
- out_pc  out  XLEN  PC travelling with the instruction.
- out_illegal  out  1  encoding not in the ISA.
- level  out  clog2(DEPTH)+1  current queue occupancy; excludes the output stage.

## Operation
- Push: in_valid && in_ready at a clock edge writes {in_instr, in_pc} at the write pointer.
- Pop: the queue head moves to the output register when the queue is non-empty and either out_valid=0 or out_ready=1. Pointers wrap modulo DEPTH.
- in_ready = (level < DEPTH) && !flush. There is no pass-through when full: a push and a pop in the same cycle while full is not allowed; in_ready stays 0.
- Push and pop in the same cycle: level is unchanged.
- Decode of the head (opcode = ir[31:26], func = ir[5:0]):
  - opcode 0: ID = func+1, func 0–3 only.
  - opcode 1–6: ID = opcode+4.
  - opcode 7: ID = func+11, func 0–1 only.
  - opcode 8–21: ID = opcode+5.
  - Anything else is illegal: ID 0, rs/rt/rd 0, out_illegal=1.
- Operand fields:
  - R-type (opcode 0, 3, 4, 19): rs = zext ir[25:21], rt = zext ir[20:16], rd = zext ir[15:11].
  - I-type (opcode 1, 2, 5, 6, 7, 8–15, 20): rs = zext ir[25:21], rt = sign-extend ir[15:0] to XLEN, rd = zext ir[20:16].
  - J-type (opcode 16–18): rs = zext ir[25:0], rt = rd = 0.
  - syscall (opcode 21): rs = rt = rd = 0.
- Output register: holds its contents while out_valid && !out_ready. If out_ready=1 and the queue is empty, out_valid drops to 0 at the next edge.
- Flush: at the edge where flush=1, level←0, pointers←0, out_valid←0. in_valid and out_ready are ignored in that cycle. Flush has priority over push and pop.

## Timing
- Reset (asynchronous assert, any time, including mid-transfer):
  - level=0, out_valid=0, in_ready=0 while reset=1.
  - out_id/out_rs/out_rt/out_rd/out_pc = 0, out_illegal=0.
  - in_ready rises in the first cycle after deassertion.
- Latency: an instruction pushed at edge k is on the outputs with out_valid=1 after edge k+1, when the output stage is free.
- Throughput: one instruction per cycle sustained when out_ready is held at 1.
- Capacity: DEPTH+1 instructions in flight (queue plus output register).
- All outputs are registered except in_ready, which is a combinational function of level and flush.

## Test plan
- Reset: assert reset mid-stream with 3 entries queued → level=0, out_valid=0, all outputs 0 immediately. First push after deassertion appears 2 edges later.
- R-type: push 0x00221801 (sub, rs=1, rt=2, rd=3) at edge k → after edge k+1: out_id=2, out_rs=1, out_rt=2, out_rd=3, out_illegal=0.
- I-type sign extension: push addi with ir[15:0]=0xFFFF, XLEN=64 → out_id=5, out_rt=0xFFFF_FFFF_FFFF_FFFF. Push jal with target 0x3FFFFFF → out_id=23, out_rs=0x3FFFFFF.
- Backpressure: out_ready=0, push continuously, DEPTH=4 → exactly 5 instructions accepted, then in_ready=0 with level=4. Set out_ready=1 → the 5 instructions emerge in order with no gaps, and in_ready returns the cycle after the first pop.
- Flush: 3 queued plus 1 valid output, pulse flush together with in_valid=1 → next cycle level=0, out_valid=0, and the flush-cycle instruction is not accepted.
- Illegal: push opcode 63, then opcode 0 with func 7, then opcode 7 with func 2 → each gives out_id=0, out_illegal=1, operands 0. A following legal instruction decodes normally.
